edge_count_ctrl: RTL and testbench

Controller that sequences the falling-edge event counter on the board's `IN` signal using the two user buttons. Raw `IN` and `buttons[1:0]` are asynchronous inputs.

- Buttons are synchronised and debounced.
- `buttons[0]` toggles counting on and off; `buttons[1]` clears.
- `IN` falling edges are detected synchronously on `clk` (no clocking on `IN`).
- A 4-bit count, status and an event pulse are driven for LEDs or downstream logic.

---
 rtl/edge_count_pkg.sv | 16 +
 rtl/edge_count_ctrl_btn_debounce.sv | 53 +++++
 rtl/edge_count_ctrl.sv | 105 ++++++++++
 tb/tb_edge_count_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_count_pkg.sv
// Shared types and constants for the IN falling-edge counter controller.
package edge_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    function automatic int unsigned dbnc_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/edge_count_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchroniser, mismatch-run debouncer and a
// one-cycle press pulse on each rising edge of the debounced level.
module btn_debounce
    import edge_count_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned   CW   = dbnc_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d       = {sync_q[0], btn_i};
        level_d      = level_q;
        level_prev_d = level_q;
        cnt_d        = '0;
        // Counter reaching LAST means this is the DEBOUNCE_CYCLES-th mismatch.
        if (sync_q[1] != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= sync_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/edge_count_ctrl.sv
// Counts synchronised falling edges of IN under button control
// (btn0 start/stop, btn1 clear); all outputs are registered.
module edge_count_ctrl
    import edge_count_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IN,
    input  logic [1:0]       buttons,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             overflow,
    output logic             edge_pulse
);

    logic start_press;
    logic clear_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (buttons[0]),
        .press_o (start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (buttons[1]),
        .press_o (clear_press)
    );

    // [1:0] synchroniser, [2] previous synced sample for edge detect
    logic [2:0]       in_sync_q, in_sync_d;
    logic             in_fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             edge_pulse_q, edge_pulse_d;
    logic             running_q, running_d;

    assign in_fall = in_sync_q[2] & ~in_sync_q[1];

    always_comb begin
        in_sync_d    = {in_sync_q[1:0], IN};
        state_d      = state_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        edge_pulse_d = 1'b0;

        if (clear_press) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (start_press) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (in_fall) begin
                        count_d      = count_q + 1'b1;
                        edge_pulse_d = 1'b1;
                        if (count_q == '1) overflow_d = 1'b1;
                    end
                    if (start_press) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_press) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sync_q    <= '0;
            state_q      <= ST_IDLE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            edge_pulse_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            in_sync_q    <= in_sync_d;
            state_q      <= state_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            edge_pulse_q <= edge_pulse_d;
            running_q    <= running_d;
        end
    end

    assign count      = count_q;
    assign running    = running_q;
    assign overflow   = overflow_q;
    assign edge_pulse = edge_pulse_q;

endmodule

// File: tb/tb_edge_count_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus, compared
// every cycle against a sample-history reference model.
module tb_edge_count_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          IN;
    logic [1:0]    buttons;
    logic [CW-1:0] count;
    logic          running;
    logic          overflow;
    logic          edge_pulse;

    always #5 clk = ~clk;

    edge_count_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IN         (IN),
        .buttons    (buttons),
        .count      (count),
        .running    (running),
        .overflow   (overflow),
        .edge_pulse (edge_pulse)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: raw per-edge sample histories, debounced levels,
    // mode (0 idle, 1 run, 2 pause) and expected outputs.
    bit q_in[$];
    bit q_b0[$];
    bit q_b1[$];
    bit lvl[2];
    bit lvl_old[2];
    int m_mode;
    int m_count;
    bit m_ovf;
    bit m_pulse;
    bit m_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit past(input int which, input int back);
        case (which)
            0:       return q_in[q_in.size() - 1 - back];
            1:       return q_b0[q_b0.size() - 1 - back];
            default: return q_b1[q_b1.size() - 1 - back];
        endcase
    endfunction

    task automatic model_reset();
        q_in.delete();
        q_b0.delete();
        q_b1.delete();
        for (int i = 0; i < int'(D) + 4; i++) begin
            q_in.push_back(1'b0);
            q_b0.push_back(1'b0);
            q_b1.push_back(1'b0);
        end
        lvl     = '{1'b0, 1'b0};
        lvl_old = '{1'b0, 1'b0};
        m_mode  = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        m_pulse = 1'b0;
        m_run   = 1'b0;
    endtask

    task automatic model_step(input logic in_v, input logic [1:0] b_v);
        bit fall;
        bit p0;
        bit p1;
        bit flip;
        q_in.push_back(in_v);
        q_b0.push_back(b_v[0]);
        q_b1.push_back(b_v[1]);
        while (q_in.size() > int'(D) + 6) begin
            void'(q_in.pop_front());
            void'(q_b0.pop_front());
            void'(q_b1.pop_front());
        end
        // a fall is seen two edges after IN is first sampled low
        fall = (past(0, 2) == 1'b0) && (past(0, 3) == 1'b1);
        p0   = lvl[0] && !lvl_old[0];
        p1   = lvl[1] && !lvl_old[1];
        m_pulse = 1'b0;
        if (p1) begin
            m_mode  = 0;
            m_count = 0;
            m_ovf   = 1'b0;
        end else begin
            if (m_mode == 1 && fall) begin
                if (m_count == 15) m_ovf = 1'b1;
                m_count = (m_count + 1) % 16;
                m_pulse = 1'b1;
            end
            if (p0) m_mode = (m_mode == 1) ? 2 : 1;
        end
        m_run = (m_mode == 1);
        // a debounced level flips once the last D synced samples all disagree
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 2; j <= int'(D) + 1; j++) begin
                if (past(b + 1, j) == lvl[b]) flip = 1'b0;
            end
            lvl_old[b] = lvl[b];
            if (flip) lvl[b] = !lvl[b];
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(count), 32'(m_count));
        check("running", 32'(running), 32'(m_run));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("edge_pulse", 32'(edge_pulse), 32'(m_pulse));
    endtask

    task automatic cycle(input logic in_v, input logic [1:0] b_v);
        @(negedge clk);
        check_outputs();
        IN      = in_v;
        buttons = b_v;
        @(posedge clk);
        if (rst_n) model_step(in_v, b_v);
    endtask

    task automatic repeat_cycle(input int n, input logic in_v, input logic [1:0] b_v);
        for (int i = 0; i < n; i++) cycle(in_v, b_v);
    endtask

    task automatic falls_slow(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 2'b00);
            cycle(1'b1, 2'b00);
            cycle(1'b0, 2'b00);
            cycle(1'b0, 2'b00);
        end
        repeat_cycle(3, 1'b1, 2'b00);
    endtask

    task automatic falls_fast(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 2'b00);
            cycle(1'b0, 2'b00);
        end
        repeat_cycle(3, 1'b1, 2'b00);
    endtask

    task automatic press(input logic [1:0] b_v);
        repeat_cycle(10, 1'b1, b_v);
        repeat_cycle(8, 1'b1, 2'b00);
    endtask

    initial begin
        logic [1:0] bv;
        logic       iv;
        int         r0;
        int         r1;

        // reset held while inputs toggle
        rst_n   = 1'b0;
        IN      = 1'b1;
        buttons = 2'b00;
        model_reset();
        for (int i = 0; i < 6; i++) cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pulse", 32'(edge_pulse), 32'd0);
        #1 rst_n = 1'b1;

        falls_slow(5);
        #1;
        check("idle_count", 32'(count), 32'd0);
        check("idle_running", 32'(running), 32'd0);

        // start: running rises 2+D edges after the first press sample
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'b01);
            #1;
            if (i == 5) check("run_early", 32'(running), 32'd0);
            if (i == 6) check("run_on_time", 32'(running), 32'd1);
        end
        repeat_cycle(8, 1'b1, 2'b00);
        falls_slow(3);
        #1 check("count3", 32'(count), 32'd3);

        // debounce: short glitch ignored, bounce then hold toggles once
        repeat_cycle(3, 1'b1, 2'b01);
        repeat_cycle(8, 1'b1, 2'b00);
        #1 check("glitch_running", 32'(running), 32'd1);
        cycle(1'b1, 2'b01);
        cycle(1'b1, 2'b00);
        cycle(1'b1, 2'b01);
        cycle(1'b1, 2'b00);
        press(2'b01);
        #1 check("bounce_pause", 32'(running), 32'd0);

        // back to run, then wrap
        press(2'b01);
        falls_fast(12);
        #1;
        check("count15", 32'(count), 32'd15);
        check("no_ovf_yet", 32'(overflow), 32'd0);
        falls_fast(2);
        #1;
        check("wrap_count", 32'(count), 32'd1);
        check("wrap_ovf", 32'(overflow), 32'd1);
        press(2'b01);
        falls_slow(4);
        #1;
        check("pause_hold", 32'(count), 32'd1);
        check("pause_running", 32'(running), 32'd0);

        // both buttons together, IN fall landing on the clear edge
        press(2'b01);
        for (int i = 0; i < 10; i++) begin
            cycle((i >= 4) ? 1'b0 : 1'b1, 2'b11);
            #1;
            if (i == 6) begin
                check("clr_count", 32'(count), 32'd0);
                check("clr_ovf", 32'(overflow), 32'd0);
                check("clr_pulse", 32'(edge_pulse), 32'd0);
                check("clr_running", 32'(running), 32'd0);
            end
        end
        repeat_cycle(8, 1'b1, 2'b00);

        // asynchronous reset in the middle of a run
        press(2'b01);
        falls_slow(7);
        #1 check("pre_rst_count", 32'(count), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_pulse", 32'(edge_pulse), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        falls_slow(2);
        #1 check("post_rst_idle", 32'(count), 32'd0);

        // random stimulus against the model
        bv = 2'b00;
        iv = 1'b1;
        r0 = 0;
        r1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (r0 == 0) begin
                bv[0] = 1'($urandom_range(0, 1));
                r0    = int'($urandom_range(1, 12));
            end else begin
                r0--;
            end
            if (r1 == 0) begin
                bv[1] = ($urandom_range(0, 7) == 0);
                r1    = int'($urandom_range(1, 12));
            end else begin
                r1--;
            end
            if ($urandom_range(0, 2) != 0) iv = ~iv;
            cycle(iv, bv);
        end

        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
